bin2bcd_sequencer: RTL
======================

BIN2BCD_SEQUENCER -- requirements
Module: bin2bcd_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be named clk and reset_n.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 load  input  1  request to convert value; sampled only in IDLE.
REQ-005 value  input  14  unsigned binary value to convert; legal range 0..9999.
REQ-006 div_start  output  1  start level to the divide-by-10 unit.
REQ-007 div_dividend  output  14  dividend to the divide-by-10 unit.
REQ-008 div_quotient  input  10  quotient from the divide-by-10 unit.
REQ-009 div_remainder  input  14  remainder from the divide-by-10 unit.
REQ-010 div_done  input  1  result-valid level from the divide-by-10 unit.
REQ-011 digits  output  16  four BCD digits; [3:0] is ones and [15:12] is thousands; registered.
REQ-012 blank  output  4  leading-zero blank mask, one bit per digit; bit 0 is always 0.
REQ-013 busy  output  1  high from load acceptance until the result is posted.
REQ-014 valid  output  1  one-cycle pulse when digits, blank and the flags update.
REQ-015 overflow  output  1  value exceeded 9999; sticky until the next accepted load.
REQ-016 error  output  1  divider timeout or remainder greater than 9; sticky until the next accepted load.

Function
REQ-017 The FSM SHALL have states IDLE, START, WAIT, STORE, RELEASE and POST.
REQ-018 In IDLE with load=1 and value<=9999: latch value into work register, clear digit index, overflow and error, set busy, and go to START.
REQ-019 In IDLE with load=1 and value>9999: set overflow=1 and digits=16'h9999, and go to POST without using the divider.
REQ-020 load while busy=1 SHALL be ignored; no queueing.
REQ-021 START: drive div_dividend=work register, assert div_start, clear timeout counter, and go to WAIT.
REQ-022 WAIT: hold div_start=1 and div_dividend stable; on div_done=1 go to STORE; increment the 8-bit timeout counter each cycle.
REQ-023 If the timeout counter reaches 255 in WAIT: set error=1, deassert div_start, and go to POST with digits unchanged from their previous value.
REQ-024 STORE: write div_remainder[3:0] into digit slot index, and set work register={4'b0,div_quotient}.
REQ-025 STORE: if div_remainder>9, set error=1.
REQ-026 STORE: deassert div_start and go to RELEASE.
REQ-027 RELEASE: wait for div_done=0, then increment the index; if the index was 3, go to POST, otherwise go to START.
REQ-028 In RELEASE, div_done stuck high SHALL be subject to the same 255-cycle timeout as in WAIT.
REQ-029 POST: compute blank with the most-significant nonzero digit and all lower digits unblanked, and digit 0 never blanked; pulse valid=1, clear busy, and go to IDLE.
REQ-030 Conversion of a legal value SHALL take exactly four divider transactions; latency from load to valid = 4 x (divider latency + 3) + 2 cycles.
REQ-031 div_start SHALL be low for at least one cycle between transactions.
REQ-032 digits, blank, overflow and error SHALL hold their values between conversions.

Reset
REQ-033 reset_n=0 SHALL force, immediately and asynchronously: state=IDLE, div_start=0, div_dividend=0, digits=0, blank=4'b1110, busy=0, valid=0, overflow=0, error=0, counters=0.
REQ-034 Reset asserted mid-conversion SHALL abandon the conversion; the first load after release SHALL convert normally.

Structure
REQ-035 A shared package SHALL hold NUM_DIGITS=4, MAX_VALUE=9999, TIMEOUT_CYCLES=255, the data widths (14, 10, 4) and the FSM state encoding.
REQ-036 No internal sub-module; the divide10 unit SHALL be instantiated beside this block in the display top and connected through the div_* ports.

Verification
REQ-037 load with value=351 -> four divider transactions; valid pulse with digits=16'h0351, blank=4'b1000, error=0.
REQ-038 value=0 -> digits=16'h0000, blank=4'b1110; value=9999 -> digits=16'h9999, blank=4'b0000.
REQ-039 value=10000 -> no div_start; valid within 2 cycles; overflow=1, digits=16'h9999.
REQ-040 Divider model that never raises div_done -> error=1 and valid pulse 256 cycles after START; busy drops.
REQ-041 load pulsed during busy with value=1234 -> ignored, first result posted unchanged; reset_n pulsed during WAIT -> all outputs at reset values, next load of 42 gives digits=16'h0042.

Source files
------------

// File: rtl/bin2bcd_sequencer_pkg.sv
// Shared constants, FSM encoding and blanking helper for the binary-to-BCD sequencer.
package bin2bcd_sequencer_pkg;

   localparam int unsigned NUM_DIGITS     = 4;
   localparam int unsigned MAX_VALUE      = 9999;
   localparam int unsigned TIMEOUT_CYCLES = 255;
   localparam int unsigned VALUE_W        = 14;
   localparam int unsigned QUOT_W         = 10;
   localparam int unsigned DIGIT_W        = 4;
   localparam int unsigned IDX_W          = 2;
   localparam int unsigned TMO_W          = 8;
   localparam int unsigned DIGITS_W       = NUM_DIGITS * DIGIT_W;
   localparam int unsigned STATE_W        = 3;

   localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] S_START   = 3'd1;
   localparam logic [STATE_W-1:0] S_WAIT    = 3'd2;
   localparam logic [STATE_W-1:0] S_STORE   = 3'd3;
   localparam logic [STATE_W-1:0] S_RELEASE = 3'd4;
   localparam logic [STATE_W-1:0] S_POST    = 3'd5;

   // A digit is blanked only when it and every more-significant digit are zero.
   function automatic logic [NUM_DIGITS-1:0] blank_mask(input logic [DIGITS_W-1:0] d);
      logic zero_above;
      blank_mask = '0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above    = zero_above && (d[i*DIGIT_W +: DIGIT_W] == '0);
         blank_mask[i] = zero_above;
      end
   endfunction

endpackage

// File: rtl/bin2bcd_sequencer.sv
// Converts a 14-bit binary value to four BCD digits by driving an external
// divide-by-10 unit four times, with overflow, timeout and bad-remainder flags.
module bin2bcd_sequencer
   import bin2bcd_sequencer_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                load,
   input  logic [VALUE_W-1:0]  value,
   output logic                div_start,
   output logic [VALUE_W-1:0]  div_dividend,
   input  logic [QUOT_W-1:0]   div_quotient,
   input  logic [VALUE_W-1:0]  div_remainder,
   input  logic                div_done,
   output logic [DIGITS_W-1:0] digits,
   output logic [NUM_DIGITS-1:0] blank,
   output logic                busy,
   output logic                valid,
   output logic                overflow,
   output logic                error
);

   localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [VALUE_W-1:0]  VALUE_MAX  = VALUE_W'(MAX_VALUE);
   localparam logic [VALUE_W-1:0]  REM_MAX    = VALUE_W'(9);
   localparam logic [DIGITS_W-1:0] DIGITS_SAT = {NUM_DIGITS{4'h9}};
   localparam logic [NUM_DIGITS-1:0] BLANK_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

   logic [STATE_W-1:0]    state_q, state_d;
   logic [VALUE_W-1:0]    work_q, work_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic [DIGITS_W-1:0]   acc_q, acc_d;
   logic                  hold_q, hold_d;
   logic                  div_start_q, div_start_d;
   logic [VALUE_W-1:0]    div_dividend_q, div_dividend_d;
   logic [DIGITS_W-1:0]   digits_q, digits_d;
   logic [NUM_DIGITS-1:0] blank_q, blank_d;
   logic                  busy_q, busy_d;
   logic                  valid_q, valid_d;
   logic                  overflow_q, overflow_d;
   logic                  error_q, error_d;

   // Next-state and output logic; hold_q suppresses the digit update on overflow or timeout.
   always_comb begin
      state_d        = state_q;
      work_d         = work_q;
      idx_d          = idx_q;
      tmo_d          = tmo_q;
      acc_d          = acc_q;
      hold_d         = hold_q;
      div_start_d    = div_start_q;
      div_dividend_d = div_dividend_q;
      digits_d       = digits_q;
      blank_d        = blank_q;
      busy_d         = busy_q;
      valid_d        = 1'b0;
      overflow_d     = overflow_q;
      error_d        = error_q;

      case (state_q)
         S_IDLE: begin
            if (load) begin
               busy_d     = 1'b1;
               error_d    = 1'b0;
               idx_d      = '0;
               acc_d      = '0;
               if (value > VALUE_MAX) begin
                  overflow_d = 1'b1;
                  digits_d   = DIGITS_SAT;
                  hold_d     = 1'b1;
                  state_d    = S_POST;
               end else begin
                  overflow_d = 1'b0;
                  work_d     = value;
                  hold_d     = 1'b0;
                  state_d    = S_START;
               end
            end
         end
         S_START: begin
            div_dividend_d = work_q;
            div_start_d    = 1'b1;
            tmo_d          = '0;
            state_d        = S_WAIT;
         end
         S_WAIT: begin
            if (div_done) begin
               state_d = S_STORE;
            end else if (tmo_q == TMO_LAST) begin
               error_d     = 1'b1;
               div_start_d = 1'b0;
               hold_d      = 1'b1;
               state_d     = S_POST;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_STORE: begin
            acc_d[idx_q*DIGIT_W +: DIGIT_W] = div_remainder[DIGIT_W-1:0];
            work_d = VALUE_W'(div_quotient);
            if (div_remainder > REM_MAX) begin
               error_d = 1'b1;
            end
            div_start_d = 1'b0;
            tmo_d       = '0;
            state_d     = S_RELEASE;
         end
         S_RELEASE: begin
            if (!div_done) begin
               idx_d   = idx_q + 1'b1;
               state_d = (idx_q == IDX_LAST) ? S_POST : S_START;
            end else if (tmo_q == TMO_LAST) begin
               error_d = 1'b1;
               hold_d  = 1'b1;
               state_d = S_POST;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_POST: begin
            if (!hold_q) begin
               digits_d = acc_q;
            end
            blank_d = blank_mask(digits_d);
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         work_q         <= '0;
         idx_q          <= '0;
         tmo_q          <= '0;
         acc_q          <= '0;
         hold_q         <= 1'b0;
         div_start_q    <= 1'b0;
         div_dividend_q <= '0;
         digits_q       <= '0;
         blank_q        <= BLANK_RST;
         busy_q         <= 1'b0;
         valid_q        <= 1'b0;
         overflow_q     <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         work_q         <= work_d;
         idx_q          <= idx_d;
         tmo_q          <= tmo_d;
         acc_q          <= acc_d;
         hold_q         <= hold_d;
         div_start_q    <= div_start_d;
         div_dividend_q <= div_dividend_d;
         digits_q       <= digits_d;
         blank_q        <= blank_d;
         busy_q         <= busy_d;
         valid_q        <= valid_d;
         overflow_q     <= overflow_d;
         error_q        <= error_d;
      end
   end

   assign div_start    = div_start_q;
   assign div_dividend = div_dividend_q;
   assign digits       = digits_q;
   assign blank        = blank_q;
   assign busy         = busy_q;
   assign valid        = valid_q;
   assign overflow     = overflow_q;
   assign error        = error_q;

endmodule
